// File: rtl/uart_arb_pkg.sv
// ==== uart_arb_pkg: shared types and sizing helpers for the UART TX arbiter ====
// ==== rev 1.0 ====
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_IDLE_TIMEOUT = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A limit of 0 means "disabled", but the counter still needs one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  localparam int GID_W = idx_width(DEF_N_REQ);

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ==== uart_rr_pick: combinational round-robin picker, search starts after last_owner ====
// ==== rev 1.0 ====
`default_nettype none

module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] cand_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [IDX_W-1:0] pick_o,
  output logic             any_o
);

  int idx;

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner_i) + k) % N_REQ;
      if (!any_o && cand_i[idx]) begin
        pick_o = IDX_W'(idx);
        any_o  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ==== uart_tx_arbiter: per-message round-robin sharing of one UART TX FIFO write port ====
// ==== rev 1.0 ====
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [N_REQ-1:0]         en_mask,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  input  logic                     tx_full,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_evt
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = cnt_width(MAX_BURST);
  localparam int IW = cnt_width(IDLE_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;
  localparam logic [IW-1:0] IDLE_LAST  = (IDLE_TIMEOUT > 0) ? IW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [0:0]    ST_IDLE    = ARB_IDLE;
  localparam logic [0:0]    ST_XFER    = ARB_XFER;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] owner_q, owner_d;
  logic [GW-1:0] last_q, last_d;
  logic          busy_q, busy_d;
  logic          to_q, to_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [N_REQ-1:0] cand;
  logic [GW-1:0]    pick;
  logic             pick_any;
  logic             in_xfer, own_valid, own_en, own_last, xfer;
  logic             rel_last, rel_burst, rel_to, rel_any;

  assign cand = req_valid & en_mask;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (GW)
  ) u_pick (
    .cand_i       (cand),
    .last_owner_i (last_q),
    .pick_o       (pick),
    .any_o        (pick_any)
  );

  always_comb begin
    in_xfer   = (state_q == ST_XFER);
    own_valid = req_valid[owner_q];
    own_en    = en_mask[owner_q];
    own_last  = req_last[owner_q];
    xfer      = in_xfer && own_valid && own_en && !tx_full;
    rel_last  = xfer && own_last;
    rel_burst = (MAX_BURST != 0) && xfer && (burst_q == BURST_LAST);
    rel_to    = (IDLE_TIMEOUT != 0) && in_xfer && !own_valid && (idle_q == IDLE_LAST);
    rel_any   = rel_last || rel_burst || rel_to || (in_xfer && !own_en);
  end

  // Accept path is combinational from state so a reset kills it at once.
  always_comb begin
    req_ready = '0;
    if (in_xfer && own_en && !tx_full) begin
      req_ready[owner_q] = 1'b1;
    end
    tx_wr   = xfer;
    tx_data = req_data[8*owner_q +: 8];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    to_d    = rel_to;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_XFER;
          owner_d = pick;
          busy_d  = 1'b1;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      ST_XFER: begin
        if (xfer) begin
          idle_d = '0;
          if ((MAX_BURST != 0) && (burst_q != BURST_LAST)) begin
            burst_d = burst_q + 1'b1;
          end
        end else if (!own_valid && (IDLE_TIMEOUT != 0) && (idle_q != IDLE_LAST)) begin
          idle_d = idle_q + 1'b1;
        end
        if (rel_any) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Requester 0 wins first after reset because the search starts at last+1.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  assign grant_id    = owner_q;
  assign busy        = busy_q;
  assign timeout_evt = to_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO between N byte-stream requesters, for example a CPU console, a debug trace unit and a DMA log channel.
- Grants ownership per message, so bytes from different requesters never interleave inside a message. A message ends on the requester's last flag.
- Arbitration is round-robin. A burst limit and a stall timeout stop one requester from starving the others.
- Sits in the Clk domain, directly in front of the UART TX FIFO write port (byte data, write strobe, full flag).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration; 0 = unlimited.
- IDLE_TIMEOUT, 1024, cycles the owner may hold the grant without offering data before it is released; 0 = disabled.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset: one clock; asynchronous, active-high.
- en_mask  in  N_REQ  per-requester enable; a disabled requester is never granted.
- req_valid  in  N_REQ  requester i offers a byte.
- req_data  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- req_last  in  N_REQ  offered byte is the last of the message.
- req_ready  out  N_REQ  byte of requester i is accepted this cycle.
- tx_data  out  8  byte to the TX FIFO.
- tx_wr  out  1  TX FIFO write strobe.
- tx_full  in  1  TX FIFO full; it must rise in the cycle after the write that fills the FIFO.
- grant_id  out  $clog2(N_REQ)  current or last owner.
- busy  out  1  a grant is active.
- timeout_evt  out  1  one-cycle pulse when a grant is released by timeout.

Behaviour:
- Reset values: state ARB_IDLE, last_owner = N_REQ-1 (requester 0 wins first), grant_id 0, busy 0, timeout_evt 0, both counters 0.
- Reset effect on outputs: req_ready and tx_wr are combinational from state, so they drop to 0 immediately when Rst asserts.
- FSM states: ARB_IDLE, ARB_XFER.
- ARB_IDLE: the candidate set is cand = req_valid & en_mask.
  - Pick the first set bit searching from last_owner+1, wrapping modulo N_REQ.
  - Register it as owner / grant_id, set busy, clear both counters, go to ARB_XFER.
  - No byte is accepted in ARB_IDLE.
  - Latency from a valid in idle to the first accepted byte is exactly 1 cycle.
- ARB_XFER accept rule:
  - xfer = req_valid[owner] & en_mask[owner] & !tx_full.
  - req_ready[owner] = en_mask[owner] & !tx_full; all other ready bits are 0.
  - tx_wr = xfer; tx_data = req_data[owner] (combinational mux).
- ARB_XFER counters:
  - On xfer: burst_cnt increments and idle_cnt clears.
  - When the owner does not offer data (!req_valid[owner]): idle_cnt increments.
  - When stalled only by tx_full: idle_cnt holds.
- ARB_XFER release to ARB_IDLE on the next edge, last_owner <= owner, busy <= 0 (grant_id keeps its value), when any of:
  - xfer & req_last[owner];
  - xfer & burst_cnt == MAX_BURST-1 (only when MAX_BURST != 0);
  - idle_cnt == IDLE_TIMEOUT-1 & !req_valid[owner] (only when IDLE_TIMEOUT != 0); this also pulses timeout_evt for 1 cycle;
  - en_mask[owner] == 0, which releases without a transfer that cycle.
- Simultaneous release causes (last byte and burst limit, for example) give a single release. timeout_evt is asserted only for the timeout cause.
- A burst-limit release in mid-message leaves the message open. The same requester re-competes in round-robin order.
- Minimum gap between grants is 1 idle cycle, so the sustained rate is MAX_BURST bytes per MAX_BURST+1 cycles.
- Counter widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST-1.
  - idle_cnt is $clog2(IDLE_TIMEOUT+1) bits.
- Full boundary: tx_full high means no strobe is issued and no timeout accrues; byte order is preserved.
- Illegal state values return to ARB_IDLE.

Decomposition:
- Package uart_arb_pkg: enum arb_state_t {ARB_IDLE, ARB_XFER}, localparam for the grant_id width, default values for MAX_BURST and IDLE_TIMEOUT.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: cand[N_REQ], last_owner.
  - Outputs: pick index, any.
  - Reusable by other shared-peripheral arbiters.

Test Plan:
- Reset, then requester 0 sends "ABC" with last on 'C' while tx_full=0.
  - tx_wr high 3 consecutive cycles starting 1 cycle after valid; tx_data 0x41, 0x42, 0x43; busy drops after 'C'; grant_id=0.
- Requesters 0 and 2 both hold 2-byte messages continuously.
  - FIFO order is 0,0,2,2,0,0 with no interleaving inside a message; one idle cycle between grants.
- MAX_BURST=4; requester 1 streams a 10-byte message; requester 3 waits with a 1-byte message.
  - Order is 4 bytes of 1, the byte of 3, 4 bytes of 1, 2 bytes of 1.
- IDLE_TIMEOUT=8; requester 0 sends 1 byte without last, then drops valid.
  - timeout_evt pulses once, 8 cycles after the last transfer; the grant moves to waiting requester 1.
- tx_full held high 50 cycles mid-message (IDLE_TIMEOUT=8).
  - No tx_wr and no timeout; transfer resumes with the correct next byte when full drops.
- Rst asserted mid-message, or en_mask[owner] cleared mid-message.
  - Rst: tx_wr, req_ready and busy go to 0 at once.
  - en_mask cleared: release next edge with no strobe.
  - After Rst releases, requester 0 is granted first.
